// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable clock divider.
package clk_div_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int DIV_MIN = 2;
    localparam int DEF_W   = 8;
    localparam int DEF_DIV = 10;

endpackage

// File: rtl/clk_div_if.sv
// Control/status bundle of clk_div_prog; hi_in exists only with CLKDIV_DUTY_EN.
interface clk_div_if
    import clk_div_pkg::*;
#(
    parameter int W = DEF_W
) ();

    logic         en;
    logic         load;
    logic [W-1:0] div_in;
`ifdef CLKDIV_DUTY_EN
    logic [W-1:0] hi_in;
`endif
    logic         clk_out;
    logic         tick;
    logic [W-1:0] div_cur;
    logic         pending;
    logic         err;

`ifdef CLKDIV_DUTY_EN
    modport master (
        output en, load, div_in, hi_in,
        input  clk_out, tick, div_cur, pending, err
    );

    modport slave (
        input  en, load, div_in, hi_in,
        output clk_out, tick, div_cur, pending, err
    );
`else
    modport master (
        output en, load, div_in,
        input  clk_out, tick, div_cur, pending, err
    );

    modport slave (
        input  en, load, div_in,
        output clk_out, tick, div_cur, pending, err
    );
`endif

endinterface

// File: rtl/clk_div_ratio_reg.sv
// Ratio register: load validation, pending ratio and boundary commit.
// CLKDIV_DUTY_EN adds a programmable high time alongside the ratio.
module clk_div_ratio_reg
    import clk_div_pkg::*;
#(
    parameter int W           = DEF_W,
    parameter int DEFAULT_DIV = DEF_DIV
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         run_i,
    input  logic         stop_i,
    input  logic         wrap_i,
    input  logic         load_i,
    input  logic [W-1:0] div_in_i,
`ifdef CLKDIV_DUTY_EN
    input  logic [W-1:0] hi_in_i,
`endif
    output logic [W-1:0] div_cur_o,
    output logic [W-1:0] div_nxt_o,
    output logic [W-1:0] hi_nxt_o,
    output logic         pending_o,
    output logic         err_o
);

    logic [W-1:0] div_cur_q, div_cur_d;
    logic [W-1:0] pend_div_q, pend_div_d;
    logic         pending_q, pending_d;
    logic         err_q, err_d;
    logic         legal;
    logic         commit;
`ifdef CLKDIV_DUTY_EN
    logic [W-1:0] hi_q, hi_d;
    logic [W-1:0] pend_hi_q, pend_hi_d;
`endif

    always_comb begin
        legal = div_in_i >= W'(DIV_MIN);
`ifdef CLKDIV_DUTY_EN
        legal = legal && (hi_in_i != '0) && (hi_in_i < div_in_i);
`endif
        // A waiting ratio lands on a wrap, on the drop to IDLE, or in IDLE.
        commit = pending_q && (!run_i || stop_i || wrap_i);
    end

    always_comb begin
        div_cur_d  = div_cur_q;
        pend_div_d = pend_div_q;
        pending_d  = pending_q;
        err_d      = load_i && !legal;
`ifdef CLKDIV_DUTY_EN
        hi_d       = hi_q;
        pend_hi_d  = pend_hi_q;
`endif
        if (commit) begin
            div_cur_d = pend_div_q;
            pending_d = 1'b0;
`ifdef CLKDIV_DUTY_EN
            hi_d      = pend_hi_q;
`endif
        end
        if (load_i && legal) begin
            if (run_i) begin
                pend_div_d = div_in_i;
                pending_d  = 1'b1;
`ifdef CLKDIV_DUTY_EN
                pend_hi_d  = hi_in_i;
`endif
            end else begin
                div_cur_d = div_in_i;
                pending_d = 1'b0;
`ifdef CLKDIV_DUTY_EN
                hi_d      = hi_in_i;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cur_q  <= W'(DEFAULT_DIV);
            pend_div_q <= '0;
            pending_q  <= 1'b0;
            err_q      <= 1'b0;
`ifdef CLKDIV_DUTY_EN
            hi_q       <= W'(DEFAULT_DIV / 2);
            pend_hi_q  <= '0;
`endif
        end else begin
            div_cur_q  <= div_cur_d;
            pend_div_q <= pend_div_d;
            pending_q  <= pending_d;
            err_q      <= err_d;
`ifdef CLKDIV_DUTY_EN
            hi_q       <= hi_d;
            pend_hi_q  <= pend_hi_d;
`endif
        end
    end

    assign div_cur_o = div_cur_q;
    assign div_nxt_o = div_cur_d;
    assign pending_o = pending_q;
    assign err_o     = err_q;
`ifdef CLKDIV_DUTY_EN
    assign hi_nxt_o  = hi_d;
`else
    assign hi_nxt_o  = div_cur_d >> 1;
`endif

endmodule

// File: rtl/clk_div_prog.sv
// Run-time programmable clock divider with clock-enable tick.
// Define CLKDIV_DUTY_EN for a programmable high time (hi_in).
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int W           = DEF_W,
    parameter int DEFAULT_DIV = DEF_DIV
) (
    input  logic      clk,
    input  logic      rst_n,
    clk_div_if.slave  bus
);

    state_e       state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic         clk_out_q, clk_out_d;
    logic         tick_q, tick_d;
    logic [W-1:0] div_cur;
    logic [W-1:0] div_nxt;
    logic [W-1:0] hi_nxt;
    logic         run;
    logic         stop;
    logic         wrap;

    assign run  = (state_q == RUN);
    assign stop = run && !bus.en;
    assign wrap = run && bus.en && (cnt_q == div_cur - W'(1));

    clk_div_ratio_reg #(
        .W           (W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ratio (
        .clk       (clk),
        .rst_n     (rst_n),
        .run_i     (run),
        .stop_i    (stop),
        .wrap_i    (wrap),
        .load_i    (bus.load),
        .div_in_i  (bus.div_in),
`ifdef CLKDIV_DUTY_EN
        .hi_in_i   (bus.hi_in),
`endif
        .div_cur_o (div_cur),
        .div_nxt_o (div_nxt),
        .hi_nxt_o  (hi_nxt),
        .pending_o (bus.pending),
        .err_o     (bus.err)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        clk_out_d = 1'b0;
        tick_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.en) begin
                    state_d   = RUN;
                    clk_out_d = 1'b1;
                    tick_d    = 1'b1;
                end
            end
            RUN: begin
                if (!bus.en) begin
                    state_d = IDLE;
                end else begin
                    cnt_d     = wrap ? '0 : cnt_q + W'(1);
                    clk_out_d = cnt_d < hi_nxt;
                    tick_d    = (cnt_d == '0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign bus.clk_out = clk_out_q;
    assign bus.tick    = tick_q;
    assign bus.div_cur = div_cur;

    logic unused_ok;
    assign unused_ok = ^div_nxt;

endmodule
